puf_eval_ctrl: RTL and testbench

//   Initiator for the N-stage arbiter PUF. Accepts a challenge over valid/ready, holds it on the PUF

---
 rtl/puf_eval_ctrl_pkg.sv | 24 ++
 rtl/puf_eval_ctrl_sync_2ff.sv | 26 ++
 rtl/puf_eval_ctrl.sv | 152 +++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/puf_eval_ctrl_pkg.sv
// Shared definitions for the arbiter-PUF evaluation controller:
// FSM state encoding, default parameter values and a sizing helper.
package puf_eval_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int unsigned DEF_N          = 64;
  localparam int unsigned DEF_K          = 15;
  localparam int unsigned DEF_SETUP_CYC  = 4;
  localparam int unsigned DEF_SETTLE_CYC = 8;

  // Larger of two wait lengths; sizes the shared wait counter.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/puf_eval_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous PUF response.
// Reset clears both stages so a stale response never leaks into a new run.
module puf_eval_ctrl_sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: takes a challenge over valid/ready,
// fires K launch pulses, samples the synchronized response once per pulse,
// majority-votes the samples and returns bit / ones count / stability flag.
module puf_eval_ctrl
  import puf_eval_ctrl_pkg::*;
#(
  parameter  int unsigned N          = DEF_N,
  parameter  int unsigned K          = DEF_K,
  parameter  int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter  int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  localparam int unsigned OW         = $clog2(K + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          chal_valid_i,
  output logic          chal_ready_o,
  input  logic [N-1:0]  chal_data_i,
  output logic [N-1:0]  puf_challenge_o,
  output logic          puf_launch_o,
  input  logic          puf_response_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic          resp_bit_o,
  output logic [OW-1:0] resp_ones_o,
  output logic          resp_stable_o
);

  localparam int unsigned WW = $clog2(max2(SETUP_CYC, SETTLE_CYC) + 1);

  // Parameter sanity: odd K avoids vote ties; SETTLE must cover the 2-FF sync.
  if ((K < 1) || ((K % 2) == 0)) begin : g_bad_k
    $error("puf_eval_ctrl: K must be odd and >= 1");
  end
  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("puf_eval_ctrl: SETUP_CYC must be >= 1");
  end
  if (SETTLE_CYC < 3) begin : g_bad_settle
    $error("puf_eval_ctrl: SETTLE_CYC must be >= 3");
  end

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [OW-1:0]   sample_q, sample_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic [N-1:0]    chal_q;
  logic            launch_q;
  logic            rvalid_q;
  logic            rbit_q;
  logic [OW-1:0]   rones_q;
  logic            rstable_q;
  logic            resp_sync;
  logic            accept;
  logic            last_sample;

  puf_eval_ctrl_sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (puf_response_i),
    .q_o   (resp_sync)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; wait_q counts down the remaining cycles of SETUP/SETTLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (chal_valid_i)           state_d = ST_SETUP;
      ST_SETUP:  if (wait_q == '0)           state_d = ST_LAUNCH;
      ST_LAUNCH:                             state_d = ST_SETTLE;
      ST_SETTLE: if (wait_q == '0)           state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = last_sample ? ST_DONE : ST_SETUP;
      ST_DONE:   if (resp_ready_i)           state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // Output / datapath decode: handshakes, counter next values.
  always_comb begin
    chal_ready_o = (state_q == ST_IDLE);
    accept       = chal_valid_i && chal_ready_o;
    last_sample  = (sample_q == OW'(K - 1));

    // Wait counter reloads whenever a timed state is entered.
    wait_d = wait_q;
    if (state_d != state_q) begin
      if (state_d == ST_SETUP)       wait_d = WW'(SETUP_CYC - 1);
      else if (state_d == ST_SETTLE) wait_d = WW'(SETTLE_CYC - 1);
      else                           wait_d = '0;
    end else if (wait_q != '0) begin
      wait_d = wait_q - WW'(1);
    end

    sample_d = sample_q;
    ones_d   = ones_q;
    if (accept) begin
      sample_d = '0;
      ones_d   = '0;
    end else if (state_q == ST_SAMPLE) begin
      ones_d = ones_q + OW'(resp_sync);
      if (!last_sample) sample_d = sample_q + OW'(1);
    end
  end

  // Counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q   <= '0;
      sample_q <= '0;
      ones_q   <= '0;
    end else begin
      wait_q   <= wait_d;
      sample_q <= sample_d;
      ones_q   <= ones_d;
    end
  end

  // Registered outputs: challenge latched only on accept, launch and valid
  // follow the next state so they line up with the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chal_q    <= '0;
      launch_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rbit_q    <= 1'b0;
      rones_q   <= '0;
      rstable_q <= 1'b0;
    end else begin
      if (accept) chal_q <= chal_data_i;
      launch_q <= (state_d == ST_LAUNCH);
      rvalid_q <= (state_d == ST_DONE);
      // Result captured once on DONE entry, frozen while the host stalls.
      if ((state_q == ST_SAMPLE) && (state_d == ST_DONE)) begin
        rbit_q    <= (ones_d > OW'(K / 2));
        rones_q   <= ones_d;
        rstable_q <= (ones_d == '0) || (ones_d == OW'(K));
      end
    end
  end

  assign puf_challenge_o = chal_q;
  assign puf_launch_o    = launch_q;
  assign resp_valid_o    = rvalid_q;
  assign resp_bit_o      = rbit_q;
  assign resp_ones_o     = rones_q;
  assign resp_stable_o   = rstable_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl: N=8, K=5, SETUP=2, SETTLE=4 (P=8, latency 40).
// The PUF is a scripted model that updates its response on each launch pulse.
module tb_puf_eval_ctrl;
  localparam int N = 8, K = 5, SU = 2, ST = 4, OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          chal_valid, chal_ready;
  logic [N-1:0]  chal_data, puf_challenge;
  logic          puf_launch, puf_response;
  logic          resp_valid, resp_ready, resp_bit, resp_stable;
  logic [OW-1:0] resp_ones;

  puf_eval_ctrl #(.N(N), .K(K), .SETUP_CYC(SU), .SETTLE_CYC(ST)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .chal_valid_i    (chal_valid),
    .chal_ready_o    (chal_ready),
    .chal_data_i     (chal_data),
    .puf_challenge_o (puf_challenge),
    .puf_launch_o    (puf_launch),
    .puf_response_i  (puf_response),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_bit_o      (resp_bit),
    .resp_ones_o     (resp_ones),
    .resp_stable_o   (resp_stable)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int n_launch = 0, c_since = 100, width_err = 0;
  int launch_t [16];
  logic [K-1:0] pat = '0;
  bit   tog_mode = 1'b0;
  logic prev_launch = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: advance past the edge, then update the PUF model.
  // Toggle mode forces 0 from 3 cycles after launch through SAMPLE, which is
  // exactly the window the 2-FF sync carries into the SAMPLE cycle.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (puf_launch) begin
      if (prev_launch) width_err++;
      if (n_launch < 16) launch_t[n_launch] = cyc;
      if (!tog_mode) puf_response = (n_launch < K) ? pat[n_launch] : 1'b0;
      n_launch++;
      c_since = 0;
    end else if (c_since < 100) begin
      c_since++;
    end
    prev_launch = puf_launch;
    if (tog_mode) puf_response = (c_since >= 3 && c_since <= 5) ? 1'b0 : ~puf_response;
  endtask

  task automatic start_chal(input logic [N-1:0] d, input logic [K-1:0] p, input bit tog,
                            output int e0);
    int guard = 0;
    chal_valid = 1'b1; chal_data = d; pat = p; tog_mode = tog; puf_response = 1'b0;
    while (!chal_ready && guard < 100) begin tick(); guard++; end
    if (guard >= 100) chk("ready_timeout", 0, 1);
    n_launch = 0; c_since = 100; prev_launch = 1'b0;
    tick();
    e0 = cyc;
    chal_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int e0, input int b, input int ones,
                              input int st);
    int guard = 0;
    while (!resp_valid && guard < 200) begin tick(); guard++; end
    chk({tag, "_valid"}, int'(resp_valid), 1);
    chk({tag, "_latency"}, cyc - e0, 40);
    chk({tag, "_bit"}, int'(resp_bit), b);
    chk({tag, "_ones"}, int'(resp_ones), ones);
    chk({tag, "_stable"}, int'(resp_stable), st);
    chk({tag, "_launches"}, n_launch, K);
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    tick();
    chk("ack_valid_low", int'(resp_valid), 0);
    resp_ready = 1'b0;
  endtask

  initial begin
    int e0, bad, guard;
    rst = 1'b1; chal_valid = 1'b0; chal_data = '0; resp_ready = 1'b0; puf_response = 1'b0;
    tick(); tick();
    chk("rst_chal_ready", int'(chal_ready), 1);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_launch", int'(puf_launch), 0);
    chk("rst_challenge", int'(puf_challenge), 0);
    chk("rst_ones", int'(resp_ones), 0);
    chk("rst_bit_stable", int'({resp_bit, resp_stable}), 0);
    rst = 1'b0;
    tick();

    // 1: always-1 PUF, timing of launches and result
    start_chal(8'hA5, 5'b11111, 1'b0, e0);
    chk("t1_challenge", int'(puf_challenge), 'hA5);
    check_result("t1", e0, 1, 5, 1);
    chk("t1_first_launch", launch_t[0] - e0, 2);
    for (int j = 1; j < K; j++) chk("t1_launch_spacing", launch_t[j] - launch_t[j-1], 8);
    chk("t1_pulse_width", width_err, 0);
    ack();

    // 2: mixed patterns
    start_chal(8'h11, 5'b10101, 1'b0, e0);
    check_result("t2a", e0, 1, 3, 0);
    ack();
    start_chal(8'h22, 5'b01010, 1'b0, e0);
    check_result("t2b", e0, 0, 2, 0);
    ack();

    // 3: stalled result, chal_valid asserted mid-run
    start_chal(8'hA5, 5'b11111, 1'b0, e0);
    chal_valid = 1'b1; chal_data = 8'h3C;
    tick();
    chk("t3_busy_ready", int'(chal_ready), 0);
    check_result("t3", e0, 1, 5, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!resp_valid || resp_ones != 3'd5 || !resp_bit || !resp_stable ||
          chal_ready || puf_challenge != 8'hA5 || puf_launch) bad++;
    end
    chk("t3_hold", bad, 0);
    chk("t3_no_extra_launch", n_launch, K);
    chal_valid = 1'b0;
    ack();

    // 4: reset during SETTLE of the third sample
    start_chal(8'hA5, 5'b11111, 1'b0, e0);
    guard = 0;
    while (n_launch < 3 && guard < 100) begin tick(); guard++; end
    tick();
    rst = 1'b1;
    #1;
    chk("t4_launch", int'(puf_launch), 0);
    chk("t4_resp_valid", int'(resp_valid), 0);
    chk("t4_chal_ready", int'(chal_ready), 1);
    chk("t4_challenge", int'(puf_challenge), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    start_chal(8'hC3, 5'b00100, 1'b0, e0);
    check_result("t4_next", e0, 0, 1, 0);
    ack();

    // 5: ack and new challenge together in DONE -> one IDLE cycle first
    start_chal(8'h11, 5'b00000, 1'b0, e0);
    check_result("t5a", e0, 0, 0, 1);
    resp_ready = 1'b1; chal_valid = 1'b1; chal_data = 8'h5A; pat = 5'b11011;
    tick();
    chk("t5_idle_valid", int'(resp_valid), 0);
    chk("t5_idle_ready", int'(chal_ready), 1);
    chk("t5_no_early_accept", int'(puf_challenge), 'h11);
    resp_ready = 1'b0;
    n_launch = 0; c_since = 100; prev_launch = 1'b0;
    tick();
    e0 = cyc;
    chal_valid = 1'b0;
    chk("t5_accept", int'(puf_challenge), 'h5A);
    chk("t5_busy", int'(chal_ready), 0);
    check_result("t5b", e0, 1, 4, 0);
    chk("t5_first_launch", launch_t[0] - e0, 2);
    ack();

    // 6: response toggling outside the sampled window has no effect
    start_chal(8'hFF, 5'b00000, 1'b1, e0);
    check_result("t6", e0, 0, 0, 1);
    tog_mode = 1'b0;
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
